// File: rtl/ccw_pkg.sv
// Shared types and constants for the CCW retry controller and its delay timer.
package ccw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DELAY = 2'd2,
        FAIL  = 2'd3
    } ccw_state_e;

    localparam int CCW_MAX_RETRIES_DEF = 3;
    localparam int RETRY_CNT_W         = 4;

endpackage

// File: rtl/ccw_delay_timer.sv
// Repeat-delay timer: start loads a length and counts 0..length-1; done pulses on the last tick.
module ccw_delay_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] length,
    output logic         done
);

    logic         run_q, run_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] len_q, len_d;

    assign done = run_q && (cnt_q == len_q - W'(1));

    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        len_d = len_q;
        if (abort) begin
            run_d = 1'b0;
            cnt_d = '0;
        end else if (start) begin
            run_d = 1'b1;
            cnt_d = '0;
            len_d = length;
        end else if (done) begin
            run_d = 1'b0;
            cnt_d = '0;
        end else if (run_q) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            len_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
            len_q <= len_d;
        end
    end

endmodule

// File: rtl/ccw_retry_ctrl.sv
// CCW retry controller: delayed repeats on subdevice busy, source toggle on no-reply/error.
// Define CCW_RETRY_BACKOFF_EN to double the repeat delay on each successive attempt.
module ccw_retry_ctrl
    import ccw_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int DELAY_TICKS = CLK_FREQ / 10,
    parameter int MAX_RETRIES = CCW_MAX_RETRIES_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ccw_sent,
    input  logic                   ccw_accepted,
    input  logic                   sd_busy,
    input  logic                   no_reply_or_err,
    output logic                   ccw_repeat_req,
    output logic                   ccw_toggle_com_src_req,
    output logic [RETRY_CNT_W-1:0] retry_cnt,
    output logic                   exhausted
);

`ifdef CCW_RETRY_BACKOFF_EN
    localparam int TICK_W = $clog2(DELAY_TICKS << (MAX_RETRIES - 1)) + 1;
`else
    localparam int TICK_W = $clog2(DELAY_TICKS) + 1;
`endif
    localparam logic [TICK_W-1:0]      BASE_LEN = TICK_W'(DELAY_TICKS);
    localparam logic [RETRY_CNT_W-1:0] MAX_R    = RETRY_CNT_W'(MAX_RETRIES);

    ccw_state_e             state_q, state_d;
    logic [RETRY_CNT_W-1:0] retry_q, retry_d;
    logic                   busy_q, err_q;
    logic                   repeat_q, repeat_d;
    logic                   toggle_q, toggle_d;
    logic                   exh_q, exh_d;
    logic                   busy_edge, err_edge;
    logic                   t_start, t_abort, t_done;
    logic [TICK_W-1:0]      len_d;

    assign busy_edge = sd_busy & ~busy_q;
    assign err_edge  = no_reply_or_err & ~err_q;

    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        repeat_d = 1'b0;
        toggle_d = 1'b0;
        t_start  = 1'b0;
        t_abort  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ccw_sent) begin
                    state_d = WAIT;
                    retry_d = '0;
                end
            end
            WAIT: begin
                if (ccw_accepted) begin
                    state_d = IDLE;
                    retry_d = '0;
                end else if (ccw_sent) begin
                    retry_d = '0;
                end else if (err_edge || busy_edge) begin
                    if (retry_q < MAX_R) begin
                        retry_d  = retry_q + RETRY_CNT_W'(1);
                        state_d  = DELAY;
                        t_start  = 1'b1;
                        toggle_d = err_edge;
                    end else begin
                        state_d = FAIL;
                    end
                end
            end
            DELAY: begin
                if (ccw_accepted) begin
                    state_d = IDLE;
                    retry_d = '0;
                    t_abort = 1'b1;
                end else if (ccw_sent) begin
                    state_d = WAIT;
                    retry_d = '0;
                    t_abort = 1'b1;
                end else if (t_done) begin
                    state_d  = WAIT;
                    repeat_d = 1'b1;
                end
            end
            FAIL: begin
                if (ccw_sent) begin
                    state_d = WAIT;
                    retry_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        exh_d = (state_d == FAIL);
    end

    // Delay length uses the post-increment attempt number, latched by the timer on start.
    always_comb begin
`ifdef CCW_RETRY_BACKOFF_EN
        len_d = BASE_LEN << (retry_d - RETRY_CNT_W'(1));
`else
        len_d = BASE_LEN;
`endif
    end

    ccw_delay_timer #(.W(TICK_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (t_start),
        .abort  (t_abort),
        .length (len_d),
        .done   (t_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            retry_q  <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            repeat_q <= 1'b0;
            toggle_q <= 1'b0;
            exh_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            retry_q  <= retry_d;
            busy_q   <= sd_busy;
            err_q    <= no_reply_or_err;
            repeat_q <= repeat_d;
            toggle_q <= toggle_d;
            exh_q    <= exh_d;
        end
    end

    assign ccw_repeat_req         = repeat_q;
    assign ccw_toggle_com_src_req = toggle_q;
    assign retry_cnt              = retry_q;
    assign exhausted              = exh_q;

endmodule

// File: tb/tb_ccw_retry_ctrl.sv
// Directed bench for ccw_retry_ctrl with DELAY_TICKS=8, MAX_RETRIES=3.
module tb_ccw_retry_ctrl;

    localparam int DT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ccw_sent = 1'b0, ccw_accepted = 1'b0, sd_busy = 1'b0, no_reply_or_err = 1'b0;
    logic       ccw_repeat_req, ccw_toggle_com_src_req, exhausted;
    logic [3:0] retry_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ccw_retry_ctrl #(.CLK_FREQ(80), .DELAY_TICKS(DT), .MAX_RETRIES(3)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .ccw_sent               (ccw_sent),
        .ccw_accepted           (ccw_accepted),
        .sd_busy                (sd_busy),
        .no_reply_or_err        (no_reply_or_err),
        .ccw_repeat_req         (ccw_repeat_req),
        .ccw_toggle_com_src_req (ccw_toggle_com_src_req),
        .retry_cnt              (retry_cnt),
        .exhausted              (exhausted)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run n cycles, returning how many repeat and toggle pulses were seen.
    task automatic idle_cycles(input int n, output int reps, output int togs);
        reps = 0;
        togs = 0;
        for (int i = 0; i < n; i++) begin
            step();
            reps += int'(ccw_repeat_req);
            togs += int'(ccw_toggle_com_src_req);
        end
    endtask

    function automatic int delay_for(input int n);
`ifdef CCW_RETRY_BACKOFF_EN
        return DT << (n - 1);
`else
        return DT;
`endif
    endfunction

    task automatic pulse_sent();
        ccw_sent = 1'b1;
        step();
        ccw_sent = 1'b0;
    endtask

    // One retry attempt from WAIT: edge, then repeat exactly delay cycles later.
    task automatic attempt(input string tag, input bit err, input int n);
        int reps, togs, d;
        d = delay_for(n);
        if (err) no_reply_or_err = 1'b1;
        else     sd_busy = 1'b1;
        step();
        sd_busy = 1'b0;
        no_reply_or_err = 1'b0;
        chk({tag, "_toggle"}, int'(ccw_toggle_com_src_req), int'(err));
        chk({tag, "_cnt"}, int'(retry_cnt), n);
        idle_cycles(d - 1, reps, togs);
        chk({tag, "_early_rep"}, reps, 0);
        chk({tag, "_extra_tog"}, togs, 0);
        step();
        chk({tag, "_rep"}, int'(ccw_repeat_req), 1);
        step();
        chk({tag, "_rep_once"}, int'(ccw_repeat_req), 0);
    endtask

    initial begin
        int reps, togs;

        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_rep", int'(ccw_repeat_req), 0);
        chk("rst_tog", int'(ccw_toggle_com_src_req), 0);
        chk("rst_cnt", int'(retry_cnt), 0);
        chk("rst_exh", int'(exhausted), 0);

        // Busy edge in IDLE is ignored.
        sd_busy = 1'b1;
        step();
        sd_busy = 1'b0;
        idle_cycles(DT + 2, reps, togs);
        chk("idle_ign_rep", reps, 0);
        chk("idle_ign_cnt", int'(retry_cnt), 0);

        // Single busy retry.
        pulse_sent();
        attempt("busy1", 1'b0, 1);
        ccw_accepted = 1'b1;
        step();
        ccw_accepted = 1'b0;
        chk("acc_clr_cnt", int'(retry_cnt), 0);

        // Exhaustion after three repeats.
        pulse_sent();
        attempt("ex1", 1'b0, 1);
        attempt("ex2", 1'b0, 2);
        attempt("ex3", 1'b0, 3);
        sd_busy = 1'b1;
        step();
        sd_busy = 1'b0;
        chk("ex_exh", int'(exhausted), 1);
        chk("ex_cnt", int'(retry_cnt), 3);
        idle_cycles(DT + 2, reps, togs);
        chk("ex_no_rep", reps, 0);
        chk("ex_hold", int'(exhausted), 1);
        ccw_accepted = 1'b1;
        step();
        ccw_accepted = 1'b0;
        chk("fail_ign_acc", int'(exhausted), 1);
        pulse_sent();
        chk("ex_clr_exh", int'(exhausted), 0);
        chk("ex_clr_cnt", int'(retry_cnt), 0);

        // Error retry toggles the command source.
        attempt("err1", 1'b1, 1);
        ccw_accepted = 1'b1;
        step();
        ccw_accepted = 1'b0;

        // Accept mid-delay aborts with no repeat and returns to IDLE.
        pulse_sent();
        sd_busy = 1'b1;
        step();
        sd_busy = 1'b0;
        idle_cycles(3, reps, togs);
        ccw_accepted = 1'b1;
        step();
        ccw_accepted = 1'b0;
        chk("abort_cnt", int'(retry_cnt), 0);
        idle_cycles(DT + 4, reps, togs);
        chk("abort_rep", reps + int'(ccw_repeat_req), 0);
        sd_busy = 1'b1;
        step();
        sd_busy = 1'b0;
        chk("abort_idle_cnt", int'(retry_cnt), 0);
        idle_cycles(DT + 2, reps, togs);
        chk("abort_idle_rep", reps, 0);

        // ccw_sent mid-delay restarts tracking.
        pulse_sent();
        sd_busy = 1'b1;
        step();
        sd_busy = 1'b0;
        idle_cycles(3, reps, togs);
        pulse_sent();
        chk("restart_cnt", int'(retry_cnt), 0);
        idle_cycles(DT + 4, reps, togs);
        chk("restart_rep", reps, 0);
        attempt("restart_wait", 1'b0, 1);
        ccw_accepted = 1'b1;
        step();
        ccw_accepted = 1'b0;

        // Simultaneous error and busy, then reset mid-delay.
        pulse_sent();
        sd_busy = 1'b1;
        no_reply_or_err = 1'b1;
        step();
        sd_busy = 1'b0;
        no_reply_or_err = 1'b0;
        chk("both_tog", int'(ccw_toggle_com_src_req), 1);
        chk("both_cnt", int'(retry_cnt), 1);
        step();
        chk("both_tog_once", int'(ccw_toggle_com_src_req), 0);
        idle_cycles(3, reps, togs);
        chk("both_pre_rst_rep", reps, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_rep", int'(ccw_repeat_req), 0);
        chk("mid_rst_tog", int'(ccw_toggle_com_src_req), 0);
        chk("mid_rst_cnt", int'(retry_cnt), 0);
        chk("mid_rst_exh", int'(exhausted), 0);
        idle_cycles(DT + 4, reps, togs);
        chk("post_rst_rep", reps, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
